// File: rtl/fp_div_iter.sv
// Iterative IEEE-754 single-precision divider: restoring radix-2, RNE, flush-to-zero.
// Optional exception flags port enabled by defining FP_DIV_FLAGS_EN.

module fp_div_step (
  input  logic [23:0] r,
  input  logic [23:0] mb,
  input  logic        first,
  output logic [23:0] r_nxt,
  output logic        qbit
);
  logic [24:0] r2;
  logic [24:0] diff;

  // The first step compares ma against mb directly to produce the 2^0 quotient bit.
  assign r2    = first ? {1'b0, r} : {r, 1'b0};
  assign diff  = r2 - {1'b0, mb};
  assign qbit  = (r2 >= {1'b0, mb});
  assign r_nxt = qbit ? diff[23:0] : r2[23:0];
endmodule

module fp_div_iter #(
  parameter int          QBITS_PER_CYCLE = 1,
  parameter logic [31:0] CANON_NAN       = 32'h7FC00000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result
`ifdef FP_DIV_FLAGS_EN
  ,
  output logic [4:0]  flags
`endif
);
  localparam int QB   = QBITS_PER_CYCLE;
  localparam int NCYC = 27 / QB;

  typedef enum logic [1:0] {IDLE, DIVIDE, ROUND, DONE} state_t;

  state_t             state;
  logic [4:0]         cnt;
  logic [23:0]        rem, mb;
  logic [26:0]        q;
  logic               sign;
  logic signed [9:0]  exp_q;

  // operand decode (exp==0 is treated as zero regardless of fraction)
  logic [7:0]  ea, eb;
  logic        s_ab, a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
  logic        spec_hit;
  logic [31:0] spec_res;
`ifdef FP_DIV_FLAGS_EN
  logic [4:0]  spec_flags, rnd_flags;
`endif

  assign ea     = a[30:23];
  assign eb     = b[30:23];
  assign s_ab   = a[31] ^ b[31];
  assign a_zero = (ea == 8'd0);
  assign b_zero = (eb == 8'd0);
  assign a_inf  = (ea == 8'hFF) && (a[22:0] == 23'd0);
  assign b_inf  = (eb == 8'hFF) && (b[22:0] == 23'd0);
  assign a_nan  = (ea == 8'hFF) && (a[22:0] != 23'd0);
  assign b_nan  = (eb == 8'hFF) && (b[22:0] != 23'd0);
  assign in_ready = (state == IDLE);

  always_comb begin
    spec_hit = 1'b1;
    spec_res = {s_ab, 31'd0};
`ifdef FP_DIV_FLAGS_EN
    spec_flags = 5'd0;
`endif
    if (a_nan || b_nan) begin
      spec_res = CANON_NAN;
    end else if ((a_zero && b_zero) || (a_inf && b_inf)) begin
      spec_res = CANON_NAN;
`ifdef FP_DIV_FLAGS_EN
      spec_flags = 5'b10000;
`endif
    end else if (a_inf) begin
      spec_res = {s_ab, 8'hFF, 23'd0};
    end else if (b_inf || a_zero) begin
      spec_res = {s_ab, 31'd0};
    end else if (b_zero) begin
      spec_res = {s_ab, 8'hFF, 23'd0};
`ifdef FP_DIV_FLAGS_EN
      spec_flags = 5'b01000;
`endif
    end else begin
      spec_hit = 1'b0;
    end
  end

  // QB restoring steps chained combinationally per DIVIDE cycle
  logic [QB:0][23:0] rch;
  logic [QB-1:0]     qstep, qcat;
  logic [26:0]       q_nxt;

  assign rch[0] = rem;
  for (genvar g = 0; g < QB; g++) begin : g_step
    fp_div_step u_step (
      .r     (rch[g]),
      .mb    (mb),
      .first ((g == 0) && (cnt == 5'd0)),
      .r_nxt (rch[g+1]),
      .qbit  (qstep[g])
    );
    assign qcat[QB-1-g] = qstep[g];
  end

  if (QB == 27) begin : g_qfull
    assign q_nxt = qcat;
  end else begin : g_qshift
    assign q_nxt = {q[26-QB:0], qcat};
  end

  // normalise + round-to-nearest-even
  logic              norm, guard, sticky, inc;
  logic [23:0]       man;
  logic [24:0]       msum;
  logic [22:0]       frac;
  logic signed [9:0] e0, e1;
  logic [31:0]       rnd_res;

  always_comb begin
    norm    = q[26];
    man     = norm ? q[26:3] : q[25:2];
    guard   = norm ? q[2] : q[1];
    sticky  = (norm ? (|q[1:0]) : q[0]) | (|rem);
    e0      = norm ? exp_q : exp_q - 10'sd1;
    inc     = guard & (sticky | man[0]);
    msum    = {1'b0, man} + {24'd0, inc};
    frac    = msum[24] ? msum[23:1] : msum[22:0];
    e1      = msum[24] ? e0 + 10'sd1 : e0;
    rnd_res = {sign, e1[7:0], frac};
`ifdef FP_DIV_FLAGS_EN
    rnd_flags = {4'd0, guard | sticky};
`endif
    if (e1 >= 10'sd255) begin
      rnd_res = {sign, 8'hFF, 23'd0};
`ifdef FP_DIV_FLAGS_EN
      rnd_flags = 5'b00101;
`endif
    end else if (e1 <= 10'sd0) begin
      rnd_res = {sign, 31'd0};
`ifdef FP_DIV_FLAGS_EN
      rnd_flags = 5'b00011;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= 5'd0;
      rem       <= 24'd0;
      mb        <= 24'd0;
      q         <= 27'd0;
      sign      <= 1'b0;
      exp_q     <= 10'sd0;
      out_valid <= 1'b0;
      result    <= 32'd0;
`ifdef FP_DIV_FLAGS_EN
      flags     <= 5'd0;
`endif
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          sign <= s_ab;
          if (spec_hit) begin
            result    <= spec_res;
`ifdef FP_DIV_FLAGS_EN
            flags     <= spec_flags;
`endif
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            rem   <= {1'b1, a[22:0]};
            mb    <= {1'b1, b[22:0]};
            q     <= 27'd0;
            cnt   <= 5'd0;
            exp_q <= $signed({2'b00, ea}) - $signed({2'b00, eb}) + 10'sd127;
            state <= DIVIDE;
          end
        end
        DIVIDE: begin
          rem <= rch[QB];
          q   <= q_nxt;
          cnt <= cnt + 5'd1;
          if (cnt == 5'(NCYC - 1)) state <= ROUND;
        end
        ROUND: begin
          result    <= rnd_res;
`ifdef FP_DIV_FLAGS_EN
          flags     <= rnd_flags;
`endif
          out_valid <= 1'b1;
          state     <= DONE;
        end
        DONE: if (out_ready) begin
          out_valid <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fp_div_iter.sv
// Bench for fp_div_iter: directed corner cases plus random ops against an integer-arithmetic model.
module tb_fp_div_iter;
  logic        clk = 1'b0;
  logic        rst_n, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] a, b, result;
`ifdef FP_DIV_FLAGS_EN
  logic [4:0]  flags;
`endif
  int vec_cnt = 0;
  int err_cnt = 0;

  always #5 clk = ~clk;

  fp_div_iter dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready), .result(result)
`ifdef FP_DIV_FLAGS_EN
    , .flags(flags)
`endif
  );

  typedef struct { logic [31:0] res; logic [4:0] fl; bit spec; } exp_t;

  // reference: exact integer quotient of the mantissas, then nearest-even by comparison with half
  function automatic exp_t model(input logic [31:0] x, input logic [31:0] y);
    exp_t r;
    longint unsigned num, qq, rm, keep, rbits, half, m;
    int e, sh;
    bit up, sg, xz, yz, xi, yi, xn, yn;
    sg = x[31] ^ y[31];
    xz = (x[30:23] == 0); yz = (y[30:23] == 0);
    xi = (x[30:23] == 8'hFF) && (x[22:0] == 0); yi = (y[30:23] == 8'hFF) && (y[22:0] == 0);
    xn = (x[30:23] == 8'hFF) && (x[22:0] != 0); yn = (y[30:23] == 8'hFF) && (y[22:0] != 0);
    r.spec = 1; r.fl = 0; r.res = {sg, 31'd0};
    if (xn || yn) r.res = 32'h7FC00000;
    else if ((xz && yz) || (xi && yi)) begin r.res = 32'h7FC00000; r.fl = 5'b10000; end
    else if (xi) r.res = {sg, 8'hFF, 23'd0};
    else if (yi || xz) r.res = {sg, 31'd0};
    else if (yz) begin r.res = {sg, 8'hFF, 23'd0}; r.fl = 5'b01000; end
    else begin
      r.spec = 0;
      num  = 64'(x[22:0] | 24'h800000) << 26;
      qq   = num / 64'(y[22:0] | 24'h800000);
      rm   = num % 64'(y[22:0] | 24'h800000);
      e    = int'(x[30:23]) - int'(y[30:23]) + 127;
      if (qq >= (64'd1 << 26)) sh = 3; else begin sh = 2; e = e - 1; end
      keep  = qq >> sh;
      rbits = qq - (keep << sh);
      half  = 64'd1 << (sh - 1);
      up    = (rbits > half) || (rbits == half && (rm != 0 || keep[0]));
      m     = keep + 64'(up);
      if (m == (64'd1 << 24)) begin m = m >> 1; e = e + 1; end
      if (e >= 255) begin r.res = {sg, 8'hFF, 23'd0}; r.fl = 5'b00101; end
      else if (e <= 0) begin r.res = {sg, 31'd0}; r.fl = 5'b00011; end
      else begin r.res = {sg, 8'(e), m[22:0]}; r.fl = {4'd0, (rbits != 0) || (rm != 0)}; end
    end
    return r;
  endfunction

  function automatic logic [31:0] gen_fp();
    logic [31:0] v;
    v = $urandom;
    case ($urandom_range(0, 11))
      0:       v[30:0] = 31'd0;
      1:       v[30:23] = 8'd0;
      2:       begin v[30:23] = 8'hFF; v[22:0] = 23'd0; end
      3:       v[30:23] = 8'hFF;
      4, 5, 6: v[30:23] = 8'($urandom_range(1, 254));
      default: v[30:23] = 8'($urandom_range(110, 144));
    endcase
    return v;
  endfunction

  // drives one op with out_ready low until the result shows, then consumes it
  task automatic run_op(input logic [31:0] ta, input logic [31:0] tbv,
                        output logic [31:0] res, output logic [4:0] fl, output int lat);
    @(negedge clk); a = ta; b = tbv; in_valid = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0; a = $urandom; b = $urandom;
    lat = -1;
    for (int i = 1; i <= 200; i++) begin
      @(negedge clk);
      if (out_valid) begin lat = i; break; end
    end
    res = result;
    fl  = 5'd0;
`ifdef FP_DIV_FLAGS_EN
    fl  = flags;
`endif
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1 out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
    repeat (2) @(negedge clk);
    vec_cnt++; if (in_ready !== 1'b1) begin err_cnt++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    vec_cnt++; if (out_valid !== 1'b0) begin err_cnt++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    vec_cnt++; if (result !== 32'd0) begin err_cnt++; $display("FAIL reset_result got %h want 0", result); end
`ifdef FP_DIV_FLAGS_EN
    vec_cnt++; if (flags !== 5'd0) begin err_cnt++; $display("FAIL reset_flags got %b want 0", flags); end
`endif
    rst_n = 1'b1;
  endtask

  localparam int ND = 11;
  localparam logic [31:0] DA [ND] = '{32'h40C00000, 32'h3F800000, 32'h3F800000, 32'hBF800000, 32'h00000000,
    32'h7FC12345, 32'h7F7FFFFF, 32'h00800000, 32'h7F800000, 32'h3F800000, 32'h00000001};
  localparam logic [31:0] DB [ND] = '{32'h40000000, 32'h40400000, 32'h3F800000, 32'h00000000, 32'h00000000,
    32'h3F800000, 32'h3F000000, 32'h40000000, 32'hFF800000, 32'hFF800000, 32'h3F800000};
  localparam logic [31:0] DR [ND] = '{32'h40400000, 32'h3EAAAAAB, 32'h3F800000, 32'hFF800000, 32'h7FC00000,
    32'h7FC00000, 32'h7F800000, 32'h00000000, 32'h7FC00000, 32'h80000000, 32'h00000000};
  localparam logic [4:0]  DF [ND] = '{5'b00000, 5'b00001, 5'b00000, 5'b01000, 5'b10000,
    5'b00000, 5'b00101, 5'b00011, 5'b10000, 5'b00000, 5'b00000};
  localparam int          DL [ND] = '{29, 29, 29, 1, 1, 1, 29, 29, 1, 1, 1};

  task automatic test_directed();
    logic [31:0] res; logic [4:0] fl; int lat;
    for (int i = 0; i < ND; i++) begin
      run_op(DA[i], DB[i], res, fl, lat);
      vec_cnt++; if (res !== DR[i]) begin err_cnt++; $display("FAIL dir%0d_result got %h want %h", i, res, DR[i]); end
      vec_cnt++; if (lat !== DL[i]) begin err_cnt++; $display("FAIL dir%0d_latency got %0d want %0d", i, lat, DL[i]); end
`ifdef FP_DIV_FLAGS_EN
      vec_cnt++; if (fl !== DF[i]) begin err_cnt++; $display("FAIL dir%0d_flags got %b want %b", i, fl, DF[i]); end
`endif
    end
  endtask

  task automatic test_random();
    logic [31:0] x, y, res; logic [4:0] fl; int lat; exp_t e;
    for (int i = 0; i < 40; i++) begin
      x = gen_fp(); y = gen_fp(); e = model(x, y);
      run_op(x, y, res, fl, lat);
      vec_cnt++; if (res !== e.res) begin err_cnt++; $display("FAIL rnd_result %h/%h got %h want %h", x, y, res, e.res); end
      vec_cnt++; if (lat !== (e.spec ? 1 : 29)) begin err_cnt++; $display("FAIL rnd_latency %h/%h got %0d want %0d", x, y, lat, e.spec ? 1 : 29); end
`ifdef FP_DIV_FLAGS_EN
      vec_cnt++; if (fl !== e.fl) begin err_cnt++; $display("FAIL rnd_flags %h/%h got %b want %b", x, y, fl, e.fl); end
`endif
    end
  endtask

  task automatic test_hold_done();
    bit seen = 0;
    @(negedge clk); a = 32'h40C00000; b = 32'h40000000; in_valid = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin @(negedge clk); seen = out_valid; end
    vec_cnt++; if (!seen) begin err_cnt++; $display("FAIL hold_timeout got no out_valid want 1"); end
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1; a = $urandom; b = $urandom;
      @(negedge clk);
      vec_cnt++;
      if (result !== 32'h40400000 || in_ready !== 1'b0 || out_valid !== 1'b1) begin
        err_cnt++; $display("FAIL hold_cycle%0d got res=%h rdy=%b vld=%b want 40400000 0 1", i, result, in_ready, out_valid);
      end
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1 out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      vec_cnt++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
        err_cnt++; $display("FAIL hold_release%0d got vld=%b rdy=%b want 0 1", i, out_valid, in_ready);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] res; logic [4:0] fl; int lat;
    @(negedge clk); a = 32'h3F800000; b = 32'h40400000; in_valid = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;
    repeat (10) @(negedge clk);
    rst_n = 1'b0; #1;
    vec_cnt++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || result !== 32'd0) begin
      err_cnt++; $display("FAIL midreset got vld=%b rdy=%b res=%h want 0 1 0", out_valid, in_ready, result);
    end
    @(negedge clk); rst_n = 1'b1;
    run_op(32'h40C00000, 32'h40000000, res, fl, lat);
    vec_cnt++; if (res !== 32'h40400000) begin err_cnt++; $display("FAIL midreset_result got %h want 40400000", res); end
    vec_cnt++; if (lat !== 29) begin err_cnt++; $display("FAIL midreset_latency got %0d want 29", lat); end
  endtask

  task automatic test_back_to_back();
    exp_t q[$]; exp_t e;
    int issued = 0;
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 2000 && (issued < 12 || q.size() > 0); cyc++) begin
      @(negedge clk);
      if (out_valid) begin
        vec_cnt++;
        if (q.size() == 0) begin err_cnt++; $display("FAIL b2b_extra got result %h want none", result); end
        else begin
          e = q.pop_front();
          if (result !== e.res) begin err_cnt++; $display("FAIL b2b_result got %h want %h", result, e.res); end
`ifdef FP_DIV_FLAGS_EN
          else if (flags !== e.fl) begin err_cnt++; $display("FAIL b2b_flags got %b want %b", flags, e.fl); end
`endif
        end
      end
      if (in_ready && issued < 12) begin
        a = gen_fp(); b = gen_fp(); in_valid = 1'b1;
        q.push_back(model(a, b)); issued++;
      end else in_valid = 1'b0;
    end
    in_valid = 1'b0; out_ready = 1'b0;
    vec_cnt++;
    if (q.size() != 0 || issued != 12) begin
      err_cnt++; $display("FAIL b2b_drain got pending=%0d issued=%0d want 0 12", q.size(), issued);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_hold_done();
    test_reset_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end
endmodule
